// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage.
// Holds the architectural {N,Z,C,V} flags and evaluates the instruction
// condition field against them. Decoder write/branch requests are gated so
// that only instructions whose condition passes change architectural state.
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_t;

  cond_t cond_code;
  logic  n, z, c, v;
  logic  wr_nz, wr_cv;

  assign cond_code = cond_t'(Cond);
  assign {n, z, c, v} = Flags;

  // Condition evaluation against the flags registered before this instruction
  always_comb begin
    CondEx = 1'b0;
    case (cond_code)
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = ~z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

  // Request gating: only an enabled, condition-passing instruction takes effect
  always_comb begin
    PCSrc    = PCS  & CondEx & en;
    RegWrite = RegW & CondEx & en;
    MemWrite = MemW & CondEx & en;
    wr_nz    = FlagW[1] & CondEx & en;
    wr_cv    = FlagW[0] & CondEx & en;
  end

  // Flags register: NZ and CV halves are independently enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= '0;
    end else begin
      if (wr_nz) Flags[3:2] <= ALUFlags[3:2];
      if (wr_cv) Flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Testbench for cond_logic: table vectors, hand-written reset/stall
// sequences, a full Cond x Flags sweep and randomized traffic against a
// behavioural reference model.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_fail   = 0;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pcs, regw, memw;
    logic       x_pcsrc, x_regwrite, x_memwrite, x_condex;
    logic [3:0] x_flags;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: condition pairs share a base test, odd codes invert it
  function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
    logic nn, zz, cc, vv, base;
    {nn, zz, cc, vv} = f;
    case (cond[3:1])
      3'd0: base = zz;
      3'd1: base = cc;
      3'd2: base = nn;
      3'd3: base = vv;
      3'd4: base = cc && !zz;
      3'd5: base = (nn == vv);
      3'd6: base = !zz && (nn == vv);
      default: base = 1'b1;
    endcase
    if (cond == 4'hF) return 1'b0;
    return base ^ cond[0];
  endfunction

  task automatic drive(input logic e, input logic [3:0] c, input logic [3:0] a,
                       input logic [1:0] fw, input logic p, input logic r, input logic m);
    en = e; Cond = c; ALUFlags = a; FlagW = fw; PCS = p; RegW = r; MemW = m;
  endtask

  logic [3:0] mflags;
  logic       ce;

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ---- reset behaviour: load flags, then assert reset between edges
    drive(1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("load_1111", Flags, 4'hF);
    #2;
    reset = 1'b1;
    drive(1'b1, 4'h0, 4'hF, 2'b00, 1'b1, 1'b0, 1'b0);
    #1;
    check("async_reset_flags", Flags, 4'h0);
    check("reset_eq_pcsrc", {3'b0, PCSrc}, 4'h0);
    drive(1'b1, 4'h1, 4'hF, 2'b00, 1'b0, 1'b1, 1'b0);
    #1;
    check("reset_ne_regwrite", {3'b0, RegWrite}, 4'h1);
    // pending write across an edge while reset is high must not land
    drive(1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_blocks_write", Flags, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---- table vectors, applied sequentially from Flags = 0000
    vecs[0]  = '{1'b1, 4'hE, 4'h4, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h4};
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4};
    vecs[2]  = '{1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4};
    vecs[3]  = '{1'b1, 4'hE, 4'h3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3};
    vecs[4]  = '{1'b1, 4'hE, 4'h8, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB};
    vecs[5]  = '{1'b1, 4'hF, 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB};
    vecs[6]  = '{1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB};
    vecs[7]  = '{1'b1, 4'hE, 4'h4, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8};
    vecs[8]  = '{1'b1, 4'h0, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8};
    vecs[9]  = '{1'b1, 4'h4, 4'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vecs[10] = '{1'b1, 4'h0, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[11] = '{1'b1, 4'hC, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].cond, vecs[i].alu, vecs[i].flagw,
            vecs[i].pcs, vecs[i].regw, vecs[i].memw);
      #1;
      check($sformatf("v%0d_condex", i),   {3'b0, CondEx},   {3'b0, vecs[i].x_condex});
      check($sformatf("v%0d_pcsrc", i),    {3'b0, PCSrc},    {3'b0, vecs[i].x_pcsrc});
      check($sformatf("v%0d_regwrite", i), {3'b0, RegWrite}, {3'b0, vecs[i].x_regwrite});
      check($sformatf("v%0d_memwrite", i), {3'b0, MemWrite}, {3'b0, vecs[i].x_memwrite});
      @(posedge clk); #1;
      check($sformatf("v%0d_flags", i), Flags, vecs[i].x_flags);
    end

    // ---- sweep every Cond against every Flags value
    for (int f = 0; f < 16; f++) begin
      @(negedge clk);
      drive(1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check($sformatf("sweep_load_%0d", f), Flags, 4'(f));
      drive(1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #0.1;
        check($sformatf("sweep_f%0d_c%0d", f, c), {3'b0, CondEx},
              {3'b0, cond_ref(4'(c), 4'(f))});
      end
    end

    // ---- randomized traffic against the reference model
    @(negedge clk);
    mflags = Flags;
    check("rand_start_flags", Flags, 4'hF);
    mflags = 4'hF;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      drive(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      ce = cond_ref(Cond, mflags);
      check("rand_flags",    Flags,              mflags);
      check("rand_condex",   {3'b0, CondEx},     {3'b0, ce});
      check("rand_pcsrc",    {3'b0, PCSrc},      {3'b0, PCS  & ce & en});
      check("rand_regwrite", {3'b0, RegWrite},   {3'b0, RegW & ce & en});
      check("rand_memwrite", {3'b0, MemWrite},   {3'b0, MemW & ce & en});
      if (en && ce && FlagW[1]) mflags[3:2] = ALUFlags[3:2];
      if (en && ce && FlagW[0]) mflags[1:0] = ALUFlags[1:0];
      @(posedge clk);
    end
    #1;
    check("rand_final_flags", Flags, mflags);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
